// File: rtl/rv64_pkg.sv
// Shared RV64 constants for the memory stage: major opcodes, func3 size
// encodings and the access FSM states.
package rv64_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Stores reuse the low four encodings (SB/SH/SW/SD = B/H/W/D).
    typedef enum logic [2:0] {
        F3_B  = 3'd0,
        F3_H  = 3'd1,
        F3_W  = 3'd2,
        F3_D  = 3'd3,
        F3_BU = 3'd4,
        F3_HU = 3'd5,
        F3_WU = 3'd6
    } func3_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Low address bits that must be zero for a size-aligned access.
    function automatic logic [2:0] size_mask(input logic [2:0] func3);
        case (func3[1:0])
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: load lane select plus sign/zero extension,
// and store data shift plus byte-strobe generation.
module mem_align
    import rv64_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      i_func3,
    input  logic [2:0]      i_offset,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [XLEN-1:0] i_load_data,
    output logic [XLEN-1:0] o_store_data,
    output logic [7:0]      o_store_strb,
    output logic [XLEN-1:0] o_load_data
);

    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_size_bits;
    logic [7:0]      w_size_strb;

    assign w_shamt = {i_offset, 3'b000};
    assign w_lane  = i_load_data >> w_shamt;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_size_bits = '1;
        w_size_strb = 8'hFF;
        case (i_func3[1:0])
            2'd0: begin
                w_size_bits = XLEN'(8'hFF);
                w_size_strb = 8'h01;
            end
            2'd1: begin
                w_size_bits = XLEN'(16'hFFFF);
                w_size_strb = 8'h03;
            end
            2'd2: begin
                w_size_bits = XLEN'(32'hFFFF_FFFF);
                w_size_strb = 8'h0F;
            end
            default: ;
        endcase
    end

    assign o_store_data = (i_store_data & w_size_bits) << w_shamt;
    assign o_store_strb = w_size_strb << i_offset;

    always_comb begin
        o_load_data = w_lane;
        case (i_func3)
            F3_B:    o_load_data = {{(XLEN-8){w_lane[7]}},   w_lane[7:0]};
            F3_H:    o_load_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            F3_W:    o_load_data = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
            F3_BU:   o_load_data = {{(XLEN-8){1'b0}},        w_lane[7:0]};
            F3_HU:   o_load_data = {{(XLEN-16){1'b0}},       w_lane[15:0]};
            F3_WU:   o_load_data = {{(XLEN-32){1'b0}},       w_lane[31:0]};
            default: o_load_data = w_lane;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one data-memory access per load/store and stalls
// until acked. Optional MEM_MISALIGN_TRAP_EN traps unaligned accesses instead.
module mem_stage
    import rv64_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_func3,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ex_data2,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign
);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e          r_state, w_next_state;
    logic            r_dmem_req, r_dmem_we;
    logic [XLEN-1:0] r_dmem_addr, r_dmem_wdata;
    logic [7:0]      r_dmem_wstrb;
    logic [2:0]      r_func3;
    logic [4:0]      r_rd;
    logic            r_is_load, r_misaligned;
    logic            r_wb_valid, r_wb_we, r_misalign;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic            w_is_load, w_is_mem, w_misaligned, w_trap, w_issue;
    logic [2:0]      w_mask, w_mem_func3, w_mem_offset;
    logic [XLEN-1:0] w_addr_aligned, w_st_data, w_ld_data;
    logic [7:0]      w_st_strb;

    assign w_is_load      = (ex_opcode == OPC_LOAD);
    assign w_is_mem       = w_is_load || (ex_opcode == OPC_STORE);
    assign w_mask         = size_mask(ex_func3);
    assign w_misaligned   = |(ex_result[2:0] & w_mask);
    assign w_addr_aligned = {ex_result[XLEN-1:3], ex_result[2:0] & ~w_mask};
    assign w_trap         = TRAP_EN && w_is_mem && w_misaligned;
    assign w_issue        = (r_state == ST_IDLE) && ex_valid && w_is_mem && !w_trap;

    // One aligner serves both directions: stores are steered at issue (IDLE),
    // loads are extended at completion (BUSY) from the held request address.
    assign w_mem_func3  = (r_state == ST_BUSY) ? r_func3 : ex_func3;
    assign w_mem_offset = (r_state == ST_BUSY) ? r_dmem_addr[2:0] : w_addr_aligned[2:0];

    mem_align #(.XLEN(XLEN)) u_align (
        .i_func3      (w_mem_func3),
        .i_offset     (w_mem_offset),
        .i_store_data (ex_data2),
        .i_load_data  (dmem_rdata),
        .o_store_data (w_st_data),
        .o_store_strb (w_st_strb),
        .o_load_data  (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_issue)  w_next_state = ST_BUSY;
            ST_BUSY: if (dmem_ack) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_wstrb <= '0;
            r_func3      <= '0;
            r_rd         <= '0;
            r_is_load    <= 1'b0;
            r_misaligned <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_issue) begin
                    r_dmem_req   <= 1'b1;
                    r_dmem_we    <= !w_is_load;
                    r_dmem_addr  <= w_addr_aligned;
                    r_dmem_wdata <= w_is_load ? '0 : w_st_data;
                    r_dmem_wstrb <= w_is_load ? '0 : w_st_strb;
                    r_func3      <= ex_func3;
                    r_rd         <= ex_rd;
                    r_is_load    <= w_is_load;
                    r_misaligned <= w_misaligned;
                end else if (ex_valid) begin
                    r_wb_valid <= 1'b1;
                    r_wb_we    <= !w_trap && (ex_rd != 5'd0);
                    r_wb_rd    <= ex_rd;
                    r_wb_data  <= ex_result;
                    r_misalign <= w_trap;
                end
            end else if (dmem_ack) begin
                r_dmem_req <= 1'b0;
                r_dmem_we  <= 1'b0;
                r_wb_valid <= 1'b1;
                r_wb_we    <= r_is_load && !r_misaligned && (r_rd != 5'd0);
                r_wb_rd    <= r_rd;
                r_wb_data  <= r_is_load ? w_ld_data : '0;
            end
        end
    end

    assign stall      = (r_state == ST_BUSY);
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_wstrb = r_dmem_wstrb;
    assign wb_valid   = r_wb_valid;
    assign wb_we      = r_wb_we;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign misalign   = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed corner cases plus randomized
// load/store/ALU traffic against an arithmetic reference model.
module tb_mem_stage;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADD   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_func3;
    logic [4:0]  ex_rd;
    logic [63:0] ex_result, ex_data2;
    logic        stall, dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        misalign;

    int n_total = 0;
    int n_bad   = 0;

    mem_stage #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_func3   (ex_func3),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .ex_data2   (ex_data2),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference load: take the addressed bytes, then sign- or zero-extend.
    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int unsigned off,
                                             input logic [2:0] f3);
        int unsigned nbits;
        logic [63:0] v, m;
        nbits = 8 << f3[1:0];
        v = rdata >> (off * 8);
        m = (nbits == 64) ? '1 : ((64'd1 << nbits) - 64'd1);
        v = v & m;
        if (!f3[2] && nbits < 64 && v[nbits-1]) v = v | ~m;
        return v;
    endfunction

    task automatic drive_idle_ex();
        ex_valid  = 1'b0;
        ex_opcode = 7'd0;
        ex_func3  = 3'd0;
        ex_rd     = 5'd0;
        ex_result = '0;
        ex_data2  = '0;
    endtask

    // Called at a negedge with ex_valid low; returns at a negedge with ex_valid low.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [63:0] res, input logic [63:0] d2,
                         input logic [63:0] rdata, input int delay);
        bit          is_ld, is_st, mis, trapped;
        logic [63:0] nb, addr_exp, byte_mask, exp_wdata;
        int unsigned off;
        logic [7:0]  strb_exp;

        is_ld    = (opc == OP_LOAD);
        is_st    = (opc == OP_STORE);
        nb       = 64'd1 << f3[1:0];
        mis      = (is_ld || is_st) && ((res % nb) != 0);
        trapped  = mis && TRAP;
        addr_exp = res - (res % nb);
        off      = int'(addr_exp % 64'd8);
        strb_exp = 8'(((16'd1 << nb) - 16'd1) << off);
        byte_mask = '0;
        for (int i = 0; i < 8; i++) if (strb_exp[i]) byte_mask[i*8 +: 8] = 8'hFF;
        exp_wdata = (d2 << (off * 8)) & byte_mask;

        ex_valid = 1'b1; ex_opcode = opc; ex_func3 = f3; ex_rd = rd;
        ex_result = res; ex_data2 = d2;
        @(negedge clk);

        if (!(is_ld || is_st) || trapped) begin
            drive_idle_ex();
            check("wb_valid", 64'(wb_valid), 64'd1);
            check("wb_we", 64'(wb_we), 64'(!trapped && rd != 0));
            check("wb_rd", 64'(wb_rd), 64'(rd));
            if (!trapped) check("wb_data", wb_data, res);
            check("misalign", 64'(misalign), 64'(trapped));
            check("stall_direct", 64'(stall), 64'd0);
            check("dmem_req_direct", 64'(dmem_req), 64'd0);
        end else begin
            for (int c = 1; c <= delay; c++) begin
                check("stall_busy", 64'(stall), 64'd1);
                check("dmem_req", 64'(dmem_req), 64'd1);
                check("dmem_we", 64'(dmem_we), 64'(is_st));
                check("dmem_addr", dmem_addr, addr_exp);
                if (is_st) begin
                    check("dmem_wstrb", 64'(dmem_wstrb), 64'(strb_exp));
                    check("dmem_wdata", dmem_wdata & byte_mask, exp_wdata);
                end
                check("wb_valid_busy", 64'(wb_valid), 64'd0);
                // An ALU op offered while stalled must be ignored.
                ex_valid = 1'b1; ex_opcode = OP_ADD; ex_rd = 5'd7;
                ex_result = {$urandom, $urandom};
                dmem_ack   = (c == delay);
                dmem_rdata = (c == delay) ? rdata : {$urandom, $urandom};
                @(negedge clk);
            end
            dmem_ack = 1'b0;
            drive_idle_ex();
            check("wb_valid_done", 64'(wb_valid), 64'd1);
            check("wb_we_done", 64'(wb_we), 64'(is_ld && !mis && rd != 0));
            check("wb_rd_done", 64'(wb_rd), 64'(rd));
            if (is_ld) check("wb_load_data", wb_data, ref_load(rdata, off, f3));
            check("stall_done", 64'(stall), 64'd0);
            check("dmem_req_done", 64'(dmem_req), 64'd0);
        end
        @(negedge clk);
        check("wb_valid_pulse", 64'(wb_valid), 64'd0);
        check("misalign_pulse", 64'(misalign), 64'd0);
    endtask

    task automatic idle_ack();
        dmem_ack = 1'b1;
        dmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        dmem_ack = 1'b0;
        check("idle_ack_wb", 64'(wb_valid), 64'd0);
        check("idle_ack_req", 64'(dmem_req), 64'd0);
        check("idle_ack_stall", 64'(stall), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stall"}, 64'(stall), 64'd0);
        check({tag, "_req"}, 64'(dmem_req), 64'd0);
        check({tag, "_we"}, 64'(dmem_we), 64'd0);
        check({tag, "_addr"}, dmem_addr, 64'd0);
        check({tag, "_wdata"}, dmem_wdata, 64'd0);
        check({tag, "_wstrb"}, 64'(dmem_wstrb), 64'd0);
        check({tag, "_wbv"}, 64'(wb_valid), 64'd0);
        check({tag, "_wbwe"}, 64'(wb_we), 64'd0);
        check({tag, "_wbrd"}, 64'(wb_rd), 64'd0);
        check({tag, "_wbdata"}, wb_data, 64'd0);
        check({tag, "_mis"}, 64'(misalign), 64'd0);
    endtask

    // Reset lands in the second BUSY cycle of a load; no writeback may follow.
    task automatic reset_mid_busy();
        ex_valid = 1'b1; ex_opcode = OP_LOAD; ex_func3 = 3'd3; ex_rd = 5'd9;
        ex_result = 64'h200; ex_data2 = '0;
        @(negedge clk);
        drive_idle_ex();
        check("rst_busy1_stall", 64'(stall), 64'd1);
        @(negedge clk);
        check("rst_busy2_req", 64'(dmem_req), 64'd1);
        rst = 1'b0;
        #1;
        check_reset_values("rst_busy");
        @(negedge clk);
        rst = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            check("rst_no_wb", 64'(wb_valid), 64'd0);
            check("rst_no_req", 64'(dmem_req), 64'd0);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  opc;
        logic [2:0]  f3;
        int          kind;

        rst = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        drive_idle_ex();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;

        issue(OP_LOAD,  3'd3, 5'd1, 64'h100, '0, 64'h1122_3344_5566_7788, 3);
        issue(OP_LOAD,  3'd0, 5'd2, 64'h103, '0, 64'h1234_5678_80AB_CDEF, 2);
        issue(OP_LOAD,  3'd4, 5'd2, 64'h103, '0, 64'h1234_5678_80AB_CDEF, 1);
        issue(OP_STORE, 3'd2, 5'd5, 64'h104, 64'h0000_0000_DEAD_BEEF, '0, 2);
        issue(OP_STORE, 3'd1, 5'd0, 64'h10A, 64'h0000_0000_0000_A5C3, '0, 1);
        issue(OP_ADD,   3'd0, 5'd3, 64'h5, '0, '0, 1);
        issue(OP_ADD,   3'd0, 5'd0, 64'h77, '0, '0, 1);
        issue(OP_LOAD,  3'd2, 5'd4, 64'h102, '0, 64'h8765_4321_F00D_CAFE, 2);
        issue(OP_LOAD,  3'd1, 5'd6, 64'h106, '0, 64'h8001_0000_0000_0000, 1);
        issue(OP_LOAD,  3'd6, 5'd6, 64'h104, '0, 64'h8001_0000_0000_0000, 1);
        idle_ack();
        reset_mid_busy();

        for (int t = 0; t < 80; t++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                opc = OP_LOAD;
                f3  = 3'($urandom_range(0, 6));
            end else if (kind == 1) begin
                opc = OP_STORE;
                f3  = 3'($urandom_range(0, 3));
            end else begin
                opc = ($urandom_range(0, 1) == 0) ? OP_ADD : 7'b0010011;
                f3  = 3'($urandom);
            end
            issue(opc, f3, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 7) == 0) idle_ack();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
